// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store unit (LB/LBU/LH/LHU/LW/SB/SH/SW) with alignment check,
// req/ack memory bus, byte-lane select with sign/zero extension and store-lane replication.
// Optional bus timeout: define LSU_BUS_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES
// cycles without mem_ack; otherwise the unit waits indefinitely and o_bus_err stays 0.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_addr_err,
    output logic        o_bus_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);
    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_op;
    logic [1:0]  r_lane;
    logic        r_done;
    logic [31:0] r_rdata;
    logic        r_addr_err;
    logic        r_bus_err;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;

    logic        w_accept;
    logic        w_misalign;
    logic        w_go;
    logic        w_timeout;
    logic        w_finish;
    logic        w_size_byte;
    logic        w_size_half;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_is_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // request decode: access size, alignment, lane masks and replicated store data
    always_comb begin
        w_size_byte = (i_op == 3'b000) || (i_op == 3'b001) || (i_op == 3'b101);
        w_size_half = (i_op == 3'b010) || (i_op == 3'b011) || (i_op == 3'b110);
        w_misalign  = (w_size_half && i_addr[0]) ||
                      (!w_size_byte && !w_size_half && (i_addr[1:0] != 2'b00));
        w_accept    = (r_state == S_IDLE) && i_start;
        w_go        = w_accept && !w_misalign;
        w_we        = i_op[2] & (i_op != 3'b100);
        w_be        = w_size_half ? (i_addr[1] ? 4'b1100 : 4'b0011) :
                      w_size_byte ? (4'b0001 << i_addr[1:0]) : 4'b1111;
        w_wdata     = w_size_byte ? {4{i_wdata[7:0]}} :
                      w_size_half ? {2{i_wdata[15:0]}} : i_wdata;
    end

    // load path: pick the addressed lane of the returned word and extend it
    always_comb begin
        w_is_load = !(r_op[2] && (r_op[1:0] != 2'b00));
        w_byte    = i_mem_rdata[{r_lane, 3'b000} +: 8];
        w_half    = i_mem_rdata[{r_lane[1], 4'b0000} +: 16];
        w_load    = (r_op == 3'b000) ? {{24{w_byte[7]}}, w_byte} :
                    (r_op == 3'b001) ? {24'h0, w_byte} :
                    (r_op == 3'b010) ? {{16{w_half[15]}}, w_half} :
                    (r_op == 3'b011) ? {16'h0, w_half} : i_mem_rdata;
    end

`ifdef LSU_BUS_TIMEOUT_EN
    logic [7:0] r_cnt;

    // wait counter: restarts on each accepted access, counts ACCESS cycles without ack
    always_ff @(posedge clk) begin
        if (rst || w_go)
            r_cnt <= 8'd0;
        else if (r_state == S_ACCESS && !i_mem_ack)
            r_cnt <= r_cnt + 8'd1;
    end

    assign w_timeout = (r_state == S_ACCESS) && !i_mem_ack &&
                       ((r_cnt + 8'd1) == 8'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_finish = (r_state == S_ACCESS) && (i_mem_ack || w_timeout);

    // next-state logic: enter ACCESS on an aligned start, leave on ack or timeout
    always_comb begin
        w_next = r_state;
        w_next = (r_state == S_IDLE) ? (w_go ? S_ACCESS : S_IDLE) :
                 (w_finish ? S_IDLE : S_ACCESS);
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // registered bus outputs, completion pulse, status flags and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= 3'b000;
            r_lane      <= 2'b00;
            r_done      <= 1'b0;
            r_rdata     <= 32'h0;
            r_addr_err  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0;
        end else begin
            r_done <= 1'b0;
            if (w_accept && w_misalign) begin
                r_done     <= 1'b1;
                r_addr_err <= 1'b1;
                r_bus_err  <= 1'b0;
            end
            if (w_go) begin
                r_op        <= i_op;
                r_lane      <= i_addr[1:0];
                r_addr_err  <= 1'b0;
                r_bus_err   <= 1'b0;
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_we;
                r_mem_addr  <= {i_addr[31:2], 2'b00};
                r_mem_be    <= w_be;
                r_mem_wdata <= w_wdata;
            end
            if (w_finish) begin
                r_mem_req <= 1'b0;
                r_done    <= 1'b1;
                r_bus_err <= w_timeout;
                if (!w_timeout && w_is_load)
                    r_rdata <= w_load;
            end
        end
    end

    assign o_busy      = (r_state == S_ACCESS);
    assign o_done      = r_done;
    assign o_rdata     = r_rdata;
    assign o_addr_err  = r_addr_err;
    assign o_bus_err   = r_bus_err;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl; timeout scenarios run when LSU_BUS_TIMEOUT_EN is defined.
module tb_lsu_ctrl;
`ifdef LSU_BUS_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [2:0]  i_op = 3'b000;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_wdata = 32'h0;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = 32'h0;
    logic        o_busy, o_done, o_addr_err, o_bus_err, o_mem_req, o_mem_we;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;

    typedef struct packed {
        logic [31:0] rdata;
        logic        aerr;
        logic        berr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_rdata = 32'h0;
    int          n_chk = 0;
    int          n_pass = 0;

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_op(i_op), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata),
        .o_addr_err(o_addr_err), .o_bus_err(o_bus_err), .o_mem_req(o_mem_req),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ld_model(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] s;
        logic [15:0] h;
        s = w >> (32'(a) * 8);
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            3'd0:    return {{24{s[7]}}, s[7:0]};
            3'd1:    return {24'h0, s[7:0]};
            3'd2:    return {{16{h[15]}}, h};
            3'd3:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // scoreboard: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && o_done) begin
            if (sb.size() == 0)
                check("sb_unexpected_done", o_done, 0);
            else begin
                e = sb.pop_front();
                check("sb_rdata", o_rdata, e.rdata);
                check("sb_addr_err", o_addr_err, e.aerr);
                check("sb_bus_err", o_bus_err, e.berr);
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] mw, input logic exp_done, input logic exp_berr);
        logic mis;
        mis = ((op == 3'd2 || op == 3'd3 || op == 3'd6) && a[0]) ||
              ((op == 3'd4 || op == 3'd7) && a[1:0] != 2'b00);
        i_start = 1'b1;
        i_op    = op;
        i_addr  = a;
        i_wdata = wd;
        if (exp_done) begin
            if (mis)
                sb.push_back({m_rdata, 1'b1, 1'b0});
            else if (op >= 3'd5 || exp_berr)
                sb.push_back({m_rdata, 1'b0, exp_berr});
            else begin
                m_rdata = ld_model(op, a[1:0], mw);
                sb.push_back({m_rdata, 2'b00});
            end
        end
    endtask

    task automatic serve(input string tag, input int waits, input logic [31:0] mw,
                         input logic [31:0] eaddr, input logic [3:0] ebe, input logic ewe,
                         input logic [31:0] ewd, input logic noise);
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int c = 0; c <= waits; c++) begin
            check({tag, "_req"}, o_mem_req, 1);
            check({tag, "_busy"}, o_busy, 1);
            check({tag, "_early_done"}, o_done, 0);
            check({tag, "_addr"}, o_mem_addr, eaddr);
            check({tag, "_be"}, o_mem_be, ebe);
            if (c == 0) begin
                check({tag, "_we"}, o_mem_we, ewe);
                if (ewe)
                    check({tag, "_wdata"}, o_mem_wdata, ewd);
            end
            if (noise && c > 0) begin
                i_start = 1'b1;
                i_op    = 3'd4;
                i_addr  = 32'hDEAD_0000;
            end
            if (c == waits) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = mw;
            end
            @(posedge clk); #1;
            i_mem_ack = 1'b0;
            i_start   = 1'b0;
        end
        check({tag, "_done"}, o_done, 1);
        check({tag, "_busy_off"}, o_busy, 0);
        check({tag, "_req_off"}, o_mem_req, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_req", o_mem_req, 0);
        check("rst_aerr", o_addr_err, 0);
        check("rst_berr", o_bus_err, 0);
        check("rst_be", o_mem_be, 0);
        check("rst_maddr", o_mem_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        drive(3'd0, 32'h1003, 32'h0, 32'h80FF1234, 1, 0);
        serve("lb", 0, 32'h80FF1234, 32'h1000, 4'b1000, 0, 0, 0);
        check("lb_rdata", o_rdata, 32'hFFFFFF80);
        @(posedge clk); #1;

        drive(3'd1, 32'h1003, 32'h0, 32'h80FF1234, 1, 0);
        serve("lbu", 0, 32'h80FF1234, 32'h1000, 4'b1000, 0, 0, 0);
        check("lbu_rdata", o_rdata, 32'h00000080);
        @(posedge clk); #1;

        drive(3'd2, 32'h2002, 32'h0, 32'h9ABC0000, 1, 0);
        serve("lh", 3, 32'h9ABC0000, 32'h2000, 4'b1100, 0, 0, 1);
        check("lh_rdata", o_rdata, 32'hFFFF9ABC);
        @(posedge clk); #1;
        check("lh_noise_req", o_mem_req, 0);
        check("lh_noise_done", o_done, 0);

        drive(3'd3, 32'h2002, 32'h0, 32'h9ABC0000, 1, 0);
        serve("lhu", 3, 32'h9ABC0000, 32'h2000, 4'b1100, 0, 0, 0);
        check("lhu_rdata", o_rdata, 32'h00009ABC);
        @(posedge clk); #1;

        drive(3'd5, 32'h3001, 32'h000000A5, 32'hFFFFFFFF, 1, 0);
        serve("sb", 0, 32'hFFFFFFFF, 32'h3000, 4'b0010, 1, 32'hA5A5A5A5, 0);
        check("sb_keep_rdata", o_rdata, 32'h00009ABC);
        @(posedge clk); #1;

        drive(3'd6, 32'h3002, 32'h1234BEEF, 32'h0, 1, 0);
        serve("sh", 1, 32'h0, 32'h3000, 4'b1100, 1, 32'hBEEFBEEF, 0);
        @(posedge clk); #1;

        drive(3'd4, 32'h4002, 32'h0, 32'h0, 1, 0);
        @(posedge clk); #1;
        i_start = 1'b0;
        check("mis_done", o_done, 1);
        check("mis_aerr", o_addr_err, 1);
        check("mis_req", o_mem_req, 0);
        check("mis_busy", o_busy, 0);
        @(posedge clk); #1;
        check("mis_done_pulse", o_done, 0);
        check("mis_aerr_hold", o_addr_err, 1);
        check("mis_req_after", o_mem_req, 0);

        drive(3'd4, 32'h4000, 32'h0, 32'hCAFEF00D, 1, 0);
        serve("lw", 0, 32'hCAFEF00D, 32'h4000, 4'b1111, 0, 0, 0);
        check("lw_aerr_clear", o_addr_err, 0);
        drive(3'd7, 32'h4004, 32'h11223344, 32'h0, 1, 0);
        serve("sw_b2b", 0, 32'h0, 32'h4004, 4'b1111, 1, 32'h11223344, 0);
        check("sw_keep_rdata", o_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;

`ifdef LSU_BUS_TIMEOUT_EN
        drive(3'd4, 32'h6000, 32'h0, 32'h0, 1, 1);
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int c = 0; c < TO; c++) begin
            check("to_req", o_mem_req, 1);
            check("to_early_done", o_done, 0);
            @(posedge clk); #1;
        end
        check("to_done", o_done, 1);
        check("to_berr", o_bus_err, 1);
        check("to_req_off", o_mem_req, 0);
        check("to_busy_off", o_busy, 0);
        @(posedge clk); #1;

        drive(3'd4, 32'h6004, 32'h0, 32'h5555AAAA, 1, 0);
        serve("to_ack", TO - 1, 32'h5555AAAA, 32'h6004, 4'b1111, 0, 0, 0);
        check("to_ack_berr", o_bus_err, 0);
        @(posedge clk); #1;
`endif

        drive(3'd4, 32'h7000, 32'h0, 32'h0, 0, 0);
        @(posedge clk); #1;
        i_start = 1'b0;
        check("rmid_req", o_mem_req, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_rdata = 32'h0;
        check("rmid_req_off", o_mem_req, 0);
        check("rmid_busy", o_busy, 0);
        check("rmid_done", o_done, 0);
        check("rmid_rdata", o_rdata, 0);
        @(posedge clk); #1;
        check("rmid_no_done", o_done, 0);

        drive(3'd1, 32'h8002, 32'h0, 32'h00C30000, 1, 0);
        serve("lbu2", 2, 32'h00C30000, 32'h8000, 4'b0100, 0, 0, 0);
        check("lbu2_rdata", o_rdata, 32'h000000C3);
        @(posedge clk); #1;

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store unit between the MEM-stage decode and data memory; the LB/LBU/LH/LHU/LW/SB/SH/SW datapath.
- Checks alignment, drives a request/acknowledge bus, byte-lane-selects and sign/zero-extends load data, and lane-replicates store data.
- Produces the final 32-bit writeback value for the register file.
- Little-endian: byte lane = addr[1:0].

Parameters:
- TIMEOUT_CYCLES, 255, cycles waited for mem_ack before a bus error is flagged (only with LSU_BUS_TIMEOUT_EN); 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new access; accepted only when busy=0.
- op  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
- addr  in  32  byte address.
- wdata  in  32  store data; low byte/half used for SB/SH.
- busy  out  1  access in flight.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result.
- addr_err  out  1  misaligned access; valid with done.
- bus_err  out  1  timeout; valid with done.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory accepted the request; read data valid this cycle.
- mem_rdata  in  32  memory read word.

Behaviour:
- Reset: synchronous, active-high; all outputs 0 on the edge where rst=1; state=IDLE.
  - rst mid-access: mem_req drops next edge; no done pulse; rdata cleared.
- States: IDLE, ACCESS.
- busy = (state==ACCESS).
- IDLE, start=1:
  - Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
    - Next edge: done=1, addr_err=1; stay IDLE; no mem_req; rdata unchanged.
  - Aligned access:
    - Latch op/addr/wdata; clear addr_err/bus_err; go to ACCESS.
    - mem_req=1 from the next cycle.
- ACCESS:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered and held stable until the cycle mem_ack=1.
  - On mem_ack: next edge state=IDLE, mem_req=0, done=1.
  - For loads, rdata is updated on that same edge.
- done and errors:
  - done is high exactly one cycle.
  - addr_err/bus_err hold their value until the next accepted start.
  - start is ignored while busy=1.
  - start in the done cycle is accepted (back-to-back allowed).
- Latency:
  - Aligned access with mem_ack in the first request cycle: start at cycle 0, mem_req at cycle 1, done at cycle 2.
  - Each wait cycle adds 1.
- mem_be:
  - Byte ops: 1<<addr[1:0].
  - Half ops: 0011 if addr[1]=0, else 1100.
  - Word ops: 1111.
  - Same masks for loads and stores.
- mem_we = op[2]&(op!=100).
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load data:
  - Byte = mem_rdata[8*addr[1:0]+:8].
  - Half = mem_rdata[16*addr[1]+:16].
  - LB/LH: sign-extend to 32.
  - LBU/LHU: zero-extend to 32.
  - LW: the word unchanged.
- Stores never modify rdata.

Optional Feature:
- Macro: LSU_BUS_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter, cleared on entry to ACCESS, increments each ACCESS cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES with mem_ack=0: next edge mem_req=0, done=1, bus_err=1, state=IDLE, rdata unchanged.
  - mem_ack in the same cycle as the timeout count: ack wins; normal completion, bus_err=0.
- Undefined:
  - No counter; the unit waits indefinitely for mem_ack.
  - bus_err is tied 0.

Test Plan:
- LB, addr=0x1003, mem_rdata=0x80FF1234, ack in first cycle:
  - mem_be=1000, mem_addr=0x1000, done at cycle 2, rdata=0xFFFFFF80.
  - Repeat as LBU: rdata=0x00000080.
- LH, addr=0x2002, mem_rdata=0x9ABC0000, ack after 3 wait cycles:
  - rdata=0xFFFF9ABC, done at cycle 5, busy high cycles 1-4.
  - Repeat as LHU: rdata=0x00009ABC.
- SB, addr=0x3001, wdata=0x000000A5:
  - mem_we=1, mem_be=0010, mem_wdata=0xA5A5A5A5; rdata unchanged after done.
- LW, addr=0x4002:
  - Next cycle done=1, addr_err=1, mem_req never asserted.
  - Following aligned LW clears addr_err.
- Back-to-back LW/SW with start asserted in the done cycle:
  - Second access accepted; mem_req asserted the cycle after done.
  - start pulses while busy=1 are ignored.
- LSU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack:
  - done=1, bus_err=1 after 4 ACCESS cycles, mem_req drops.
  - Rerun with ack on the 4th cycle: normal done, bus_err=0.
  - rst asserted mid-ACCESS: mem_req=0 next cycle, no done.
